// File: rtl/common_demux2_stream_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one input stream,
// two output streams, route select and packet-open status.
interface common_demux2_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic             I_VALID;
    logic             I_LAST;
    logic             I_READY;
    logic             S;
    logic [WIDTH-1:0] Z0;
    logic             Z0_VALID;
    logic             Z0_LAST;
    logic             Z0_READY;
    logic [WIDTH-1:0] Z1;
    logic             Z1_VALID;
    logic             Z1_LAST;
    logic             Z1_READY;
    logic             BUSY;

    modport slave (
        input  I, I_VALID, I_LAST, S, Z0_READY, Z1_READY,
        output I_READY, Z0, Z0_VALID, Z0_LAST,
        output Z1, Z1_VALID, Z1_LAST, BUSY
    );

    modport master (
        output I, I_VALID, I_LAST, S, Z0_READY, Z1_READY,
        input  I_READY, Z0, Z0_VALID, Z0_LAST,
        input  Z1, Z1_VALID, Z1_LAST, BUSY
    );
endinterface

// File: rtl/common_demux2_stream.sv
// Registered 1-to-2 stream demux; route is taken on a packet's
// first beat and held until its last beat is accepted.
module common_demux2_stream #(
    parameter int WIDTH = 8
) (
    input logic                         CLK,
    input logic                         RST_N,
    common_demux2_stream_if.slave       bus
);
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             lock_q, lock_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             dst_q, dst_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic sel_ready;
    logic in_ready;
    logic accept;

    // Only the port currently holding the beat can drain it.
    assign sel_ready = dst_q ? bus.Z1_READY : bus.Z0_READY;
    assign in_ready  = !vld_q || sel_ready;
    assign accept    = bus.I_VALID && in_ready;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        vld_d   = vld_q;
        last_d  = last_q;
        dst_d   = dst_q;
        data_d  = data_q;
        if (accept) begin
            vld_d  = 1'b1;
            data_d = bus.I;
            last_d = bus.I_LAST;
            unique case (state_q)
                IDLE: begin
                    dst_d  = bus.S;
                    lock_d = bus.S;
                    if (!bus.I_LAST) state_d = LOCK;
                end
                LOCK: begin
                    dst_d = lock_q;
                    if (bus.I_LAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (sel_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            dst_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    assign bus.I_READY  = in_ready;
    assign bus.Z0       = data_q;
    assign bus.Z1       = data_q;
    assign bus.Z0_LAST  = last_q;
    assign bus.Z1_LAST  = last_q;
    assign bus.Z0_VALID = vld_q && !dst_q;
    assign bus.Z1_VALID = vld_q && dst_q;
    assign bus.BUSY     = (state_q == LOCK);
endmodule

// File: tb/tb_common_demux2_stream.sv
// Bench for common_demux2_stream: directed scenarios plus random
// traffic checked against a per-port expected-beat queue model.
module tb_common_demux2_stream;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    common_demux2_stream_if #(.WIDTH(W)) bus ();

    common_demux2_stream #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    // Model: beats waiting on each port, packet-open flag and its route.
    beat_t q0[$];
    beat_t q1[$];
    bit    m_open;
    bit    m_route;

    function automatic bit exp_ready();
        if (q0.size() > 0) return bus.Z0_READY;
        if (q1.size() > 0) return bus.Z1_READY;
        return 1'b1;
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_open  = 1'b0;
        m_route = 1'b0;
    endtask

    task automatic tick();
        bit    rdy;
        bit    r;
        beat_t b;
        rdy = exp_ready();
        if (q0.size() > 0 && bus.Z0_READY) void'(q0.pop_front());
        if (q1.size() > 0 && bus.Z1_READY) void'(q1.pop_front());
        if (bus.I_VALID && rdy) begin
            r   = m_open ? m_route : bus.S;
            b.d = bus.I;
            b.l = bus.I_LAST;
            if (r) q1.push_back(b);
            else   q0.push_back(b);
            if (!m_open && !bus.I_LAST) begin
                m_open  = 1'b1;
                m_route = bus.S;
            end else if (m_open && bus.I_LAST) begin
                m_open = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [W-1:0] d, bit l, logic s);
        bus.I_VALID = v;
        bus.I       = d;
        bus.I_LAST  = l;
        bus.S       = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(0, '0, 0, 0);
        bus.Z0_READY = 1'b1;
        bus.Z1_READY = 1'b1;
        model_clear();
        #12 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Z0_VALID, bus.Z1_VALID, bus.Z0_LAST, bus.Z1_LAST,
             bus.BUSY} !== 5'b0 || bus.Z0 !== '0 || bus.Z1 !== '0) begin
            errors++;
            $display("FAIL reset_outputs: v0=%b v1=%b l0=%b l1=%b busy=%b z0=%h z1=%h want all 0",
                     bus.Z0_VALID, bus.Z1_VALID, bus.Z0_LAST, bus.Z1_LAST,
                     bus.BUSY, bus.Z0, bus.Z1);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.I_READY !== 1'b1 || bus.BUSY !== 1'b0 ||
            bus.Z0_VALID !== 1'b0 || bus.Z1_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b busy=%b v0=%b v1=%b want 1 0 0 0",
                     bus.I_READY, bus.BUSY, bus.Z0_VALID, bus.Z1_VALID);
        end
        tick();
    endtask

    task automatic test_single();
        drive(1, 8'hA5, 1, 1);
        @(negedge clk);
        checks++;
        if (bus.I_READY !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", bus.I_READY);
        end
        tick();
        drive(0, '0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.Z1_VALID !== 1'b1 || bus.Z1 !== 8'hA5 ||
            bus.Z1_LAST !== 1'b1 || bus.Z0_VALID !== 1'b0 ||
            bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_route: v1=%b z1=%h l1=%b v0=%b busy=%b want 1 a5 1 0 0",
                     bus.Z1_VALID, bus.Z1, bus.Z1_LAST, bus.Z0_VALID, bus.BUSY);
        end
        tick();
    endtask

    task automatic test_lock();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1, 8'h10 + W'(k), k == 3, k[0]);
            else       drive(0, '0, 0, 0);
            @(negedge clk);
            checks++;
            if (bus.BUSY !== (k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL lock_busy k=%0d: got %b want %b",
                         k, bus.BUSY, (k >= 1 && k <= 3));
            end
            if (k >= 1) begin
                checks++;
                if (bus.Z0_VALID !== 1'b1 || bus.Z1_VALID !== 1'b0 ||
                    bus.Z0 !== 8'h10 + W'(k - 1) ||
                    bus.Z0_LAST !== (k == 4)) begin
                    errors++;
                    $display("FAIL lock_beat k=%0d: v0=%b v1=%b z0=%h l0=%b want 1 0 %h %b",
                             k, bus.Z0_VALID, bus.Z1_VALID, bus.Z0,
                             bus.Z0_LAST, 8'h10 + W'(k - 1), (k == 4));
                end
            end
            tick();
        end
        drive(0, '0, 0, 0);
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got[$];
        int           idx;
        drive(1, 8'h30, 0, 1);
        @(negedge clk);
        tick();
        drive(1, 8'h31, 0, 0);
        bus.Z1_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.Z0_READY = k[0];
            @(negedge clk);
            checks++;
            if (bus.I_READY !== 1'b0 || bus.Z1_VALID !== 1'b1 ||
                bus.Z1 !== 8'h30 || bus.Z0_VALID !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall k=%0d: rdy=%b v1=%b z1=%h v0=%b want 0 1 30 0",
                         k, bus.I_READY, bus.Z1_VALID, bus.Z1, bus.Z0_VALID);
            end
            tick();
        end
        bus.Z1_READY = 1'b1;
        bus.Z0_READY = 1'b0;
        idx = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.Z1_VALID && bus.Z1_READY) got.push_back(bus.Z1);
            if (bus.I_VALID && bus.I_READY) idx++;
            tick();
            if (idx < 3) drive(1, 8'h30 + W'(idx), idx == 2, 0);
            else         drive(0, '0, 0, 0);
        end
        bus.Z0_READY = 1'b1;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 8'h30 + W'(i)) begin
                    errors++;
                    $display("FAIL bp_order i=%0d: got %h want %h",
                             i, got[i], 8'h30 + W'(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d[3];
        bit           l[3];
        bit           s[3];
        d = '{8'h40, 8'h41, 8'h50};
        l = '{0, 1, 1};
        s = '{0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(1, d[k], l[k], s[k]);
            else       drive(0, '0, 0, 0);
            @(negedge clk);
            if (k < 3) begin
                checks++;
                if (bus.I_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready k=%0d: got %b want 1", k, bus.I_READY);
                end
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (bus.Z0_VALID !== 1'b1 || bus.Z1_VALID !== 1'b0 ||
                    bus.Z0 !== d[k-1] || bus.Z0_LAST !== l[k-1]) begin
                    errors++;
                    $display("FAIL b2b_z0 k=%0d: v0=%b v1=%b z0=%h l0=%b want 1 0 %h %b",
                             k, bus.Z0_VALID, bus.Z1_VALID, bus.Z0,
                             bus.Z0_LAST, d[k-1], l[k-1]);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.Z1_VALID !== 1'b1 || bus.Z0_VALID !== 1'b0 ||
                    bus.Z1 !== 8'h50 || bus.Z1_LAST !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_z1: v1=%b v0=%b z1=%h l1=%b want 1 0 50 1",
                             bus.Z1_VALID, bus.Z0_VALID, bus.Z1, bus.Z1_LAST);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 8'h60, 0, 0);
        @(negedge clk);
        tick();
        drive(1, 8'h61, 0, 1);
        @(negedge clk);
        tick();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %b want 1", bus.BUSY);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (bus.Z0_VALID !== 1'b0 || bus.Z1_VALID !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.Z0 !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: v0=%b v1=%b busy=%b z0=%h want 0 0 0 00",
                     bus.Z0_VALID, bus.Z1_VALID, bus.BUSY, bus.Z0);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1, 8'h62, 1, 1);
        @(negedge clk);
        tick();
        drive(0, '0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.Z1_VALID !== 1'b1 || bus.Z1 !== 8'h62 ||
            bus.Z0_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_new: v1=%b z1=%h v0=%b busy=%b want 1 62 0 0",
                     bus.Z1_VALID, bus.Z1, bus.Z0_VALID, bus.BUSY);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.I_VALID  = ($urandom_range(0, 3) != 0);
            bus.I        = W'($urandom);
            bus.I_LAST   = ($urandom_range(0, 3) == 0);
            bus.S        = m_open ? 1'bx : 1'($urandom);
            bus.Z0_READY = ($urandom_range(0, 3) != 0);
            bus.Z1_READY = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (bus.I_READY !== exp_ready() || bus.BUSY !== m_open ||
                bus.Z0_VALID !== (q0.size() > 0) ||
                bus.Z1_VALID !== (q1.size() > 0)) begin
                errors++;
                $display("FAIL rand_ctrl k=%0d: rdy=%b busy=%b v0=%b v1=%b want %b %b %b %b",
                         k, bus.I_READY, bus.BUSY, bus.Z0_VALID, bus.Z1_VALID,
                         exp_ready(), m_open, (q0.size() > 0), (q1.size() > 0));
            end
            if (q0.size() > 0) begin
                checks++;
                if (bus.Z0 !== q0[0].d || bus.Z0_LAST !== q0[0].l) begin
                    errors++;
                    $display("FAIL rand_z0 k=%0d: z0=%h l0=%b want %h %b",
                             k, bus.Z0, bus.Z0_LAST, q0[0].d, q0[0].l);
                end
            end
            if (q1.size() > 0) begin
                checks++;
                if (bus.Z1 !== q1[0].d || bus.Z1_LAST !== q1[0].l) begin
                    errors++;
                    $display("FAIL rand_z1 k=%0d: z1=%h l1=%b want %h %b",
                             k, bus.Z1, bus.Z1_LAST, q1[0].d, q1[0].l);
                end
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_lock();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end
endmodule
